// File: rtl/pipe_stage_reg_if.sv
// Valid/ready payload channel between pipeline stages.
// The producer drives valid and data; the consumer drives ready.
interface pipe_stage_reg_if #(
    parameter int WIDTH = 32
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with optional 2-entry skid buffer,
// synchronous flush and saturating stall/bubble perf counters.
module pipe_stage_reg #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter bit               SKID_EN = 1'b1,
    parameter int               CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    pipe_stage_reg_if.slave     up,
    pipe_stage_reg_if.master    dn,
    input  logic                flush,
    input  logic                cnt_clr,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    bubble_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_d;
    logic             rdy_q;
    logic             fire_in;
    logic             fire_out;
    logic             stall_inc;
    logic             bubble_inc;

    // Registered ready breaks the out_ready -> in_ready path when skidding
    assign up.ready = SKID_EN ? rdy_q
                              : ((state_q == EMPTY) | dn.ready);

    assign dn.valid = (state_q != EMPTY);
    assign dn.data  = dn.valid ? main_q : RST_VAL;

    assign fire_in  = up.valid & up.ready;
    assign fire_out = dn.valid & dn.ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (fire_in) begin
                    state_d = FULL;
                    main_d  = up.data;
                end
            end
            FULL: begin
                if (fire_in && !fire_out) begin
                    state_d = SKID_EN ? SKID : FULL;
                    skid_d  = up.data;
                end else if (fire_in && fire_out) begin
                    main_d  = up.data;
                end else if (fire_out) begin
                    state_d = EMPTY;
                end
            end
            SKID: begin
                if (fire_out) begin
                    state_d = FULL;
                    main_d  = skid_q;
                    skid_d  = RST_VAL;
                end
            end
            default: begin
                state_d = EMPTY;
                main_d  = RST_VAL;
                skid_d  = RST_VAL;
            end
        endcase
        // Flush overrides everything, including a same-cycle accept
        if (flush) begin
            state_d = EMPTY;
            main_d  = RST_VAL;
            skid_d  = RST_VAL;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            main_q  <= RST_VAL;
            skid_q  <= RST_VAL;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            rdy_q   <= (state_d != SKID);
        end
    end

    assign stall_inc  = dn.valid & ~dn.ready & (stall_cnt != '1);
    assign bubble_inc = ~dn.valid & dn.ready & (bubble_cnt != '1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (stall_inc) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (bubble_inc) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: skid variant (CNT_W=4) and
// single-entry variant (SKID_EN=0) against a FIFO-based model.
module tb_pipe_stage_reg;

    localparam logic [31:0] RV = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  iv;
    logic [1:0]  orr;
    logic [1:0]  fl;
    logic [1:0]  cc;
    logic [31:0] id;
    logic [3:0]  sc_a;
    logic [3:0]  bc_a;
    logic [15:0] sc_b;
    logic [15:0] bc_b;

    int checks   = 0;
    int failures = 0;

    int          n   [2];
    logic [31:0] fifo[2][2];
    int          st  [2];
    int          bu  [2];

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.WIDTH(32)) up_a ();
    pipe_stage_reg_if #(.WIDTH(32)) dn_a ();
    pipe_stage_reg_if #(.WIDTH(32)) up_b ();
    pipe_stage_reg_if #(.WIDTH(32)) dn_b ();

    assign up_a.valid = iv[0];
    assign up_a.data  = id;
    assign dn_a.ready = orr[0];
    assign up_b.valid = iv[1];
    assign up_b.data  = id;
    assign dn_b.ready = orr[1];

    pipe_stage_reg #(
        .WIDTH(32), .RST_VAL(RV), .SKID_EN(1'b1), .CNT_W(4)
    ) dut_a (
        .clk(clk), .rst(rst), .up(up_a), .dn(dn_a),
        .flush(fl[0]), .cnt_clr(cc[0]),
        .stall_cnt(sc_a), .bubble_cnt(bc_a)
    );

    pipe_stage_reg #(
        .WIDTH(32), .RST_VAL(RV), .SKID_EN(1'b0), .CNT_W(16)
    ) dut_b (
        .clk(clk), .rst(rst), .up(up_b), .dn(dn_b),
        .flush(fl[1]), .cnt_clr(cc[1]),
        .stall_cnt(sc_b), .bubble_cnt(bc_b)
    );

    task automatic chk(input string nm, input int d,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d got=%h exp=%h t=%0t",
                     nm, d, act, exp, $time);
        end
    endtask

    // One model step per DUT, sampled 1 time unit before the edge
    task automatic step(input int d);
        logic        ir_o;
        logic        ov_o;
        logic [31:0] od_o;
        logic [31:0] sc_o;
        logic [31:0] bc_o;
        int          mx;
        logic        exp_ir;
        logic        pre_v;
        logic        fin;
        logic        fout;
        if (d == 0) begin
            ir_o = up_a.ready;
            ov_o = dn_a.valid;
            od_o = dn_a.data;
            sc_o = 32'(sc_a);
            bc_o = 32'(bc_a);
            mx   = 15;
        end else begin
            ir_o = up_b.ready;
            ov_o = dn_b.valid;
            od_o = dn_b.data;
            sc_o = 32'(sc_b);
            bc_o = 32'(bc_b);
            mx   = 65535;
        end
        if (!rst) begin
            chk("rst_in_ready", d, 32'(ir_o), 32'd1);
            chk("rst_out_valid", d, 32'(ov_o), 32'd0);
            chk("rst_out_data", d, od_o, RV);
            chk("rst_stall", d, sc_o, 32'd0);
            chk("rst_bubble", d, bc_o, 32'd0);
            n[d]  = 0;
            st[d] = 0;
            bu[d] = 0;
            return;
        end
        exp_ir = (d == 0) ? (n[d] < 2)
                          : (n[d] == 0 || orr[d]);
        pre_v  = (n[d] > 0);
        chk("in_ready", d, 32'(ir_o), 32'(exp_ir));
        chk("out_valid", d, 32'(ov_o), 32'(pre_v));
        chk("out_data", d, od_o, pre_v ? fifo[d][0] : RV);
        chk("stall_cnt", d, sc_o, 32'(st[d]));
        chk("bubble_cnt", d, bc_o, 32'(bu[d]));
        fin  = iv[d] && exp_ir;
        fout = pre_v && orr[d];
        if (fout) begin
            fifo[d][0] = fifo[d][1];
            n[d]       = n[d] - 1;
        end
        if (fl[d]) begin
            n[d] = 0;
        end else if (fin) begin
            fifo[d][n[d]] = id;
            n[d]          = n[d] + 1;
        end
        if (cc[d]) begin
            st[d] = 0;
            bu[d] = 0;
        end else begin
            if (pre_v && !orr[d] && st[d] < mx) st[d]++;
            if (!pre_v && orr[d] && bu[d] < mx) bu[d]++;
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            n[d]  = 0;
            st[d] = 0;
            bu[d] = 0;
        end
        forever begin
            @(negedge clk);
            #4;
            step(0);
            step(1);
        end
    end

    task automatic drive(input logic v, input logic [31:0] d,
                         input logic r, input logic f,
                         input logic c);
        @(negedge clk);
        iv  = {v, v};
        id  = d;
        orr = {r, r};
        fl  = {f, f};
        cc  = {c, c};
    endtask

    initial begin
        iv  = '0;
        orr = '0;
        fl  = '0;
        cc  = '0;
        id  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        // single transfer then a stream of 8 at full rate
        drive(1'b1, 32'hA5, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            drive(1'b1, $urandom, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        // back-pressure fills main then skid, ordered drain
        drive(1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h99, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        // flush discards a same-cycle input
        drive(1'b1, 32'h33, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h44, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        // long stall saturates the 4-bit counter
        drive(1'b1, 32'h77, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++)
            drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        // async reset while two entries are held
        drive(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h66, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_valid", 0, 32'(dn_a.valid), 32'd0);
        chk("async_data", 0, dn_a.data, RV);
        chk("async_stall", 0, 32'(sc_a), 32'd0);
        chk("async_ready", 0, 32'(up_a.ready), 32'd1);
        chk("async_valid", 1, 32'(dn_b.valid), 32'd0);
        chk("async_data", 1, dn_b.data, RV);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        // randomised traffic on both variants
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                iv[d]  = ($urandom_range(0, 3) != 0);
                orr[d] = ($urandom_range(0, 2) != 0);
                fl[d]  = ($urandom_range(0, 19) == 0);
                cc[d]  = ($urandom_range(0, 59) == 0);
            end
            id = $urandom;
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
